bcd_countdown_mmss: RTL

//  Four-digit BCD countdown timer, MM:SS from 59:59 down to 00:00, the decrementing counterpart of the
//  0-59 up-counter chain. A preset is loaded, counted down one second per tick while running, and a

---
 rtl/bcd_countdown_mmss.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_mmss.sv
// rtl/bcd_countdown_mmss.sv - MM:SS BCD countdown timer with load/start/stop control and expiry pulse
module bcd_countdown_mmss #(
  parameter int AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] pre_m1,
  input  logic [3:0] pre_m0,
  input  logic [3:0] pre_s1,
  input  logic [3:0] pre_s0,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] r_preset;
  logic        r_running;
  logic        r_expired;
  logic        r_done;

  logic [15:0] w_cnt_nxt;
  logic [15:0] w_preset_nxt;
  logic        w_done_nxt;
  logic        w_running_nxt;
  logic        w_expired_nxt;
  logic [15:0] w_load_val;
  logic [15:0] w_dec;
  logic        w_zero;
  logic        w_dec_zero;
  logic        w_load_ok;

  assign w_load_val = {(pre_m1 > 4'd5) ? 4'd5 : pre_m1,
                       (pre_m0 > 4'd9) ? 4'd9 : pre_m0,
                       (pre_s1 > 4'd5) ? 4'd5 : pre_s1,
                       (pre_s0 > 4'd9) ? 4'd9 : pre_s0};

  assign w_zero     = (r_cnt == 16'h0000);
  assign w_dec_zero = (w_dec == 16'h0000);
  assign w_load_ok  = load && (r_state != S_RUN);

  // Borrow ripples s0 -> s1 -> m0 -> m1; digits outside the active chain hold.
  always_comb begin
    w_dec = r_cnt;
    if (r_cnt[3:0] != 4'd0) begin
      w_dec[3:0] = r_cnt[3:0] - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_cnt[7:4] != 4'd0) begin
        w_dec[7:4] = r_cnt[7:4] - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_cnt[11:8] != 4'd0) begin
          w_dec[11:8] = r_cnt[11:8] - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_cnt[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'h0000;
      r_preset  <= 16'h0000;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_preset  <= w_preset_nxt;
      r_running <= w_running_nxt;
      r_expired <= w_expired_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_preset_nxt = r_preset;
    w_done_nxt   = 1'b0;
    if (w_load_ok) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = w_load_val;
      w_preset_nxt = w_load_val;
    end else begin
      case (r_state)
        S_IDLE, S_EXPIRED: begin
          if (start && !stop && !w_zero) w_state_nxt = S_RUN;
        end
        S_PAUSED: begin
          if (start && !stop) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            w_state_nxt = S_PAUSED;
          end else if (tick) begin
            // A tick at 00:00 only happens with auto-reload: it restarts from the preset.
            if (w_zero) begin
              if (AUTO_RELOAD != 0) w_cnt_nxt = r_preset;
            end else begin
              w_cnt_nxt = w_dec;
              if (w_dec_zero) begin
                w_done_nxt = 1'b1;
                if (AUTO_RELOAD == 0) w_state_nxt = S_EXPIRED;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_expired_nxt = (w_state_nxt == S_EXPIRED);
  end

  assign m1      = r_cnt[15:12];
  assign m0      = r_cnt[11:8];
  assign s1      = r_cnt[7:4];
  assign s0      = r_cnt[3:0];
  assign running = r_running;
  assign expired = r_expired;
  assign done    = r_done;

endmodule
